vc_arbiter_ctrl: RTL
====================

VC_ARBITER_CTRL -- requirements
Module: vc_arbiter_ctrl

Interface
REQ-001 Parameter DATA_WIDTH, default 6, width of every data word.
REQ-002 Parameter STARVE_LIMIT, default 4, consecutive VC0 grants allowed while VC1 waits (guard build only).
REQ-003 clk  input  1  single clock; all state updates on posedge clk.
REQ-004 reset  input  1  synchronous, active-high; sampled on posedge clk.
REQ-005 empty_vc0  input  1  VC0 FIFO empty flag.
REQ-006 empty_vc1  input  1  VC1 FIFO empty flag.
REQ-007 data_vc0  input  DATA_WIDTH  VC0 FIFO head word, show-ahead, valid while empty_vc0=0.
REQ-008 data_vc1  input  DATA_WIDTH  VC1 FIFO head word, show-ahead, valid while empty_vc1=0.
REQ-009 pause  input  1  downstream cannot accept; blocks all grants.
REQ-010 pop_vc0  output  1  combinational pop strobe to VC0 FIFO.
REQ-011 pop_vc1  output  1  combinational pop strobe to VC1 FIFO.
REQ-012 data_out  output  DATA_WIDTH  registered forwarded word.
REQ-013 valid_out  output  1  registered; data_out valid this cycle.
REQ-014 src_vc1  output  1  registered; 1 = data_out came from VC1.

Function
REQ-015 Grant eligibility per cycle: reset=0, pause=0, and selected VC non-empty.
REQ-016 Default policy: VC0 strict priority; VC1 granted only when empty_vc0=1.
REQ-017 At most one of pop_vc0/pop_vc1 high in any cycle.
REQ-018 Pop is asserted in the same cycle as the grant decision; popped word appears on data_out with valid_out=1 on the following posedge (latency 1).
REQ-019 No grant in a cycle -> valid_out=0 next cycle; data_out holds last value.
REQ-020 pause=1 -> both pops 0 that cycle, regardless of FIFO state; no word dropped or duplicated.
REQ-021 Both FIFOs empty -> no pop, FSM to IDLE.
REQ-022 FSM states IDLE, SERVE_VC0, SERVE_VC1; state = VC granted this cycle, IDLE if none; next state registered.
REQ-023 Transitions: any state -> SERVE_VC0 on VC0 grant, -> SERVE_VC1 on VC1 grant, -> IDLE on no grant (including pause).
REQ-024 Continuous pop without bubbles: back-to-back grants permitted every cycle.

Reset
REQ-025 reset=1 -> pop_vc0=0, pop_vc1=0 combinationally in that cycle; reset overrides pause and FIFO flags.
REQ-026 After reset edge: state=IDLE, valid_out=0, data_out=0, src_vc1=0, starvation counter=0.
REQ-027 Reset mid-stream discards nothing already popped; word popped before reset cycle still emitted if its edge precedes reset assertion.

Configuration
REQ-028 Macro ARB_STARVE_GUARD_EN defined: counter counts consecutive VC0 grants while empty_vc1=0; on reaching STARVE_LIMIT the next eligible grant goes to VC1 and counter clears.
REQ-029 Counter clears on any VC1 grant, on empty_vc1=1, and on reset; holds during pause.
REQ-030 Macro undefined: pure strict priority per REQ-016, no counter logic instantiated.

Structure
REQ-031 Shared package holds FSM state typedef (IDLE/SERVE_VC0/SERVE_VC1), DATA_WIDTH default 6, STARVE_LIMIT default 4.
REQ-032 One sub-module arb_starve_counter (counter, limit compare, clear), instantiated only under ARB_STARVE_GUARD_EN.

Verification
REQ-033 VC0 holds 1,2,3; VC1 empty; pause=0 -> pop_vc0 three cycles, data_out 1,2,3 on consecutive cycles, src_vc1=0.
REQ-034 Both FIFOs non-empty, VC0 head 4, VC1 head 9 -> pop_vc0 first, data_out=4 next cycle; VC1 served only after VC0 drains (guard off).
REQ-035 Guard on, STARVE_LIMIT=4, both FIFOs full -> grant pattern VC0,VC0,VC0,VC0,VC1 repeating; src_vc1=1 every fifth word.
REQ-036 pause=1 for 3 cycles mid-stream with 6 words queued -> no pops, valid_out=0 for 3 cycles, all 6 words output once, order kept.
REQ-037 reset=1 for one cycle while streaming -> pops 0 that cycle, valid_out=0, data_out=0, state IDLE next cycle, traffic resumes cycle after.
REQ-038 Both FIFOs empty -> pops 0, valid_out=0, state IDLE indefinitely.

Source files
------------

// File: rtl/vc_arbiter_ctrl_pkg.sv
// Shared types and defaults for the two-VC arbiter: FSM state encoding,
// default data width and default starvation limit.
package vc_arbiter_ctrl_pkg;

    localparam int DATA_WIDTH_DEF   = 6;
    localparam int STARVE_LIMIT_DEF = 4;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        SERVE_VC0 = 2'd1,
        SERVE_VC1 = 2'd2
    } arb_state_e;

endpackage

// File: rtl/vc_arbiter_ctrl_if.sv
// Bundle of FIFO-side and downstream signals of the arbiter.
// The slave modport is the arbiter; the master modport is its environment.
interface vc_arbiter_ctrl_if #(
    parameter int DATA_WIDTH = vc_arbiter_ctrl_pkg::DATA_WIDTH_DEF
);
    logic                  empty_vc0;
    logic                  empty_vc1;
    logic [DATA_WIDTH-1:0] data_vc0;
    logic [DATA_WIDTH-1:0] data_vc1;
    logic                  pause;
    logic                  pop_vc0;
    logic                  pop_vc1;
    logic [DATA_WIDTH-1:0] data_out;
    logic                  valid_out;
    logic                  src_vc1;

    modport master (
        output empty_vc0, empty_vc1, data_vc0, data_vc1, pause,
        input  pop_vc0, pop_vc1, data_out, valid_out, src_vc1
    );

    modport slave (
        input  empty_vc0, empty_vc1, data_vc0, data_vc1, pause,
        output pop_vc0, pop_vc1, data_out, valid_out, src_vc1
    );
endinterface

// File: rtl/arb_starve_counter.sv
// Counts consecutive VC0 grants while VC1 waits; flags starvation once the
// count reaches STARVE_LIMIT. Used only when ARB_STARVE_GUARD_EN is defined.
module arb_starve_counter #(
    parameter int STARVE_LIMIT = vc_arbiter_ctrl_pkg::STARVE_LIMIT_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic vc0_grant,
    input  logic vc1_grant,
    input  logic vc1_waiting,
    output logic starve
);
    localparam int CW = $clog2(STARVE_LIMIT + 1);
    localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

    logic [CW-1:0] count_q;

    // Pause produces no grants, so the count naturally holds through it.
    always_ff @(posedge clk) begin
        if (reset || vc1_grant || !vc1_waiting) begin
            count_q <= '0;
        end else if (vc0_grant && (count_q < LIMIT)) begin
            count_q <= count_q + 1'b1;
        end
    end

    assign starve = (count_q >= LIMIT);

endmodule

// File: rtl/vc_arbiter_ctrl.sv
// Two-VC arbiter: VC0 strict priority, pops are combinational, forwarded word
// registered. Define ARB_STARVE_GUARD_EN to bound VC1 starvation by STARVE_LIMIT.
module vc_arbiter_ctrl
    import vc_arbiter_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH   = DATA_WIDTH_DEF
`ifdef ARB_STARVE_GUARD_EN
   ,parameter int STARVE_LIMIT = STARVE_LIMIT_DEF
`endif
) (
    input  logic             clk,
    input  logic             reset,
    vc_arbiter_ctrl_if.slave bus
);
    arb_state_e            state_q;
    arb_state_e            next_state;
    logic                  pop_vc0;
    logic                  pop_vc1;
    logic                  starve;
    logic [DATA_WIDTH-1:0] data_q;

`ifdef ARB_STARVE_GUARD_EN
    arb_starve_counter #(
        .STARVE_LIMIT (STARVE_LIMIT)
    ) u_starve (
        .clk         (clk),
        .reset       (reset),
        .vc0_grant   (pop_vc0),
        .vc1_grant   (pop_vc1),
        .vc1_waiting (!bus.empty_vc1),
        .starve      (starve)
    );
`else
    assign starve = 1'b0;
`endif

    // The next state is simply the VC granted this cycle, so the grant
    // decision and next-state logic are one process.
    always_comb begin
        // NOTE: defaults first so every path assigns and no latch is inferred.
        pop_vc0    = 1'b0;
        pop_vc1    = 1'b0;
        next_state = IDLE;
        if (!reset && !bus.pause) begin
            if (!bus.empty_vc1 && (bus.empty_vc0 || starve)) begin
                pop_vc1    = 1'b1;
                next_state = SERVE_VC1;
            end else if (!bus.empty_vc0) begin
                pop_vc0    = 1'b1;
                next_state = SERVE_VC0;
            end
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: non-blocking so every register samples pre-edge values.
        if (reset) begin
            state_q <= IDLE;
            data_q  <= '0;
        end else begin
            state_q <= next_state;
            if (pop_vc1) begin
                data_q <= bus.data_vc1;
            end else if (pop_vc0) begin
                data_q <= bus.data_vc0;
            end
        end
    end

    // Registered state already encodes whether and from where a word arrived.
    assign bus.pop_vc0   = pop_vc0;
    assign bus.pop_vc1   = pop_vc1;
    assign bus.data_out  = data_q;
    assign bus.valid_out = (state_q != IDLE);
    assign bus.src_vc1   = (state_q == SERVE_VC1);

endmodule
